// File: rtl/fifo_narrow_to_wide_if.sv
// Handshake bundle for the narrow-write / wide-read FIFO.
// master = producer/consumer side, slave = the FIFO itself.
interface fifo_narrow_to_wide_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                    write_i;
    logic [DATA_WIDTH-1:0]   write_data_i;
    logic                    read_i;
    logic [2*DATA_WIDTH-1:0] read_data_o;
    logic                    empty_o;
    logic                    full_o;
    logic [ADDR_WIDTH:0]     count_o;

    modport master (
        output write_i, write_data_i, read_i,
        input  read_data_o, empty_o, full_o, count_o
    );

    modport slave (
        input  write_i, write_data_i, read_i,
        output read_data_o, empty_o, full_o, count_o
    );
endinterface

// File: rtl/fifo_narrow_to_wide.sv
// Synchronous FIFO: one narrow word written per cycle, one pair of words read per cycle
// as a single wide word. Storage is a narrow register file read asynchronously.
module fifo_narrow_to_wide #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    fifo_narrow_to_wide_if.slave bus
);
    localparam int                  DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] PAIR_COUNT = (ADDR_WIDTH+1)'(2);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH-1:0] rptr_hi;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  empty;
    logic                  full;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flags come from registered count only, so no input reaches an output combinationally.
    assign empty = count < PAIR_COUNT;
    assign full  = count == FULL_COUNT;
    assign wr_ok = bus.write_i & ~full;
    assign rd_ok = bus.read_i & ~empty;

    // rptr is always even, so the partner word never crosses the wrap point.
    assign rptr_hi = rptr + ADDR_WIDTH'(1);

    always_comb begin
        count_nxt = count;
        if (wr_ok) count_nxt = count_nxt + (ADDR_WIDTH+1)'(1);
        if (rd_ok) count_nxt = count_nxt - PAIR_COUNT;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + ADDR_WIDTH'(1);
            if (rd_ok) rptr <= rptr + ADDR_WIDTH'(2);
            count <= count_nxt;
        end
    end

    // Storage holds data only; it is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (wr_ok) mem[wptr] <= bus.write_data_i;
    end

    assign bus.read_data_o = {mem[rptr_hi], mem[rptr]};
    assign bus.empty_o     = empty;
    assign bus.full_o      = full;
    assign bus.count_o     = count;
endmodule

// File: tb/tb_fifo_narrow_to_wide.sv
// Bench for fifo_narrow_to_wide: directed vector table, wrap stream, mid-cycle reset,
// and a randomized run against a queue-based reference model.
module tb_fifo_narrow_to_wide;
    logic clk;
    logic reset_i;

    fifo_narrow_to_wide_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    fifo_narrow_to_wide #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [7:0]  wdata;
        bit          chk_rd;
        logic [15:0] exp_rd;
        int          exp_cnt;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] mq[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input bit wr, input bit rd, input logic [7:0] wd,
                                input bit chk, input logic [15:0] er, input int ec);
        vec_t v;
        v.wr = wr; v.rd = rd; v.wdata = wd; v.chk_rd = chk; v.exp_rd = er; v.exp_cnt = ec;
        vecs.push_back(v);
    endfunction

    task automatic step(input bit w, input bit r, input logic [7:0] d);
        bus.write_i      = w;
        bus.read_i       = r;
        bus.write_data_i = d;
        @(posedge clk);
        #1;
        bus.write_i = 1'b0;
        bus.read_i  = 1'b0;
    endtask

    task automatic model_cycle(input bit w, input bit r, input logic [7:0] d);
        bit exp_wr;
        bit exp_rd;
        bus.write_i      = w;
        bus.read_i       = r;
        bus.write_data_i = d;
        #1;
        if (r && mq.size() >= 2) check("rnd rdata", 32'(bus.read_data_o), 32'({mq[1], mq[0]}));
        exp_wr = w && (mq.size() < 16);
        exp_rd = r && (mq.size() >= 2);
        if (exp_rd) begin
            void'(mq.pop_front());
            void'(mq.pop_front());
        end
        if (exp_wr) mq.push_back(d);
        @(posedge clk);
        #1;
        check("rnd count", 32'(bus.count_o), 32'(mq.size()));
        check("rnd empty", 32'(bus.empty_o), 32'(mq.size() < 2));
        check("rnd full",  32'(bus.full_o),  32'(mq.size() == 16));
    endtask

    initial begin
        int          nrd;
        logic [15:0] exp_w;
        int          wp[4];
        int          rp[4];

        bus.write_i = 1'b0; bus.read_i = 1'b0; bus.write_data_i = '0;
        reset_i = 1'b1;
        #1;
        check("reset empty", 32'(bus.empty_o), 32'd1);
        check("reset full",  32'(bus.full_o),  32'd0);
        check("reset count", 32'(bus.count_o), 32'd0);
        @(negedge clk);
        reset_i = 1'b0;

        // Fill to 16, then one rejected write
        for (int i = 0; i < 16; i++) add(1, 0, 8'(i), 0, '0, i + 1);
        add(1, 0, 8'hAA, 0, '0, 16);
        // Drain 8 pairs, then one rejected read
        for (int k = 0; k < 8; k++) add(0, 1, 8'h00, 1, {8'(2*k+1), 8'(2*k)}, 14 - 2*k);
        add(0, 1, 8'h00, 0, '0, 0);
        // Odd leftover
        add(1, 0, 8'h11, 0, '0, 1);
        add(1, 0, 8'h22, 0, '0, 2);
        add(1, 0, 8'h33, 0, '0, 3);
        add(0, 1, 8'h00, 1, 16'h2211, 1);
        add(0, 1, 8'h00, 0, '0, 1);
        add(1, 0, 8'h44, 0, '0, 2);
        add(0, 1, 8'h00, 1, 16'h4433, 0);
        // Simultaneous read+write while full
        for (int i = 0; i < 16; i++) add(1, 0, 8'(8'h80 + i), 0, '0, i + 1);
        add(1, 1, 8'hEE, 1, 16'h8180, 14);
        for (int k = 0; k < 7; k++) add(0, 1, 8'h00, 1, {8'(8'h83 + 2*k), 8'(8'h82 + 2*k)}, 12 - 2*k);
        // Simultaneous read+write with a single word stored
        add(1, 0, 8'h30, 0, '0, 1);
        add(1, 1, 8'h31, 0, '0, 2);
        add(0, 1, 8'h00, 1, 16'h3130, 0);

        foreach (vecs[i]) begin
            bus.write_i      = vecs[i].wr;
            bus.read_i       = vecs[i].rd;
            bus.write_data_i = vecs[i].wdata;
            #1;
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d rdata", i), 32'(bus.read_data_o), 32'(vecs[i].exp_rd));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d count", i), 32'(bus.count_o), 32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d empty", i), 32'(bus.empty_o), 32'(vecs[i].exp_cnt < 2));
            check($sformatf("vec%0d full", i),  32'(bus.full_o),  32'(vecs[i].exp_cnt == 16));
        end
        bus.write_i = 1'b0;
        bus.read_i  = 1'b0;

        // Wrap-around stream: 40 writes with reads whenever a pair is available
        nrd = 0;
        for (int i = 0; i < 40; i++) begin
            bus.write_i      = 1'b1;
            bus.write_data_i = 8'(i);
            bus.read_i       = ~bus.empty_o;
            #1;
            if (bus.read_i) begin
                exp_w = {8'(2*nrd + 1), 8'(2*nrd)};
                check("wrap rdata", 32'(bus.read_data_o), 32'(exp_w));
                nrd++;
            end
            @(posedge clk);
            #1;
            check("wrap count bound", 32'(bus.count_o <= 5'd16), 32'd1);
        end
        bus.write_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            bus.read_i = ~bus.empty_o;
            #1;
            if (bus.read_i) begin
                exp_w = {8'(2*nrd + 1), 8'(2*nrd)};
                check("wrap drain rdata", 32'(bus.read_data_o), 32'(exp_w));
                nrd++;
            end
            @(posedge clk);
            #1;
        end
        bus.read_i = 1'b0;
        check("wrap pairs read", 32'(nrd), 32'd20);
        check("wrap final count", 32'(bus.count_o), 32'd0);

        // Reset between edges with 9 words stored
        for (int i = 0; i < 9; i++) step(1, 0, 8'(8'hC0 + i));
        check("pre-reset count", 32'(bus.count_o), 32'd9);
        #3;
        reset_i = 1'b1;
        #1;
        check("async reset empty", 32'(bus.empty_o), 32'd1);
        check("async reset full",  32'(bus.full_o),  32'd0);
        check("async reset count", 32'(bus.count_o), 32'd0);
        @(negedge clk);
        reset_i = 1'b0;
        step(1, 0, 8'h55);
        step(1, 0, 8'h66);
        check("post-reset rdata", 32'(bus.read_data_o), 32'h6655);
        step(0, 1, 8'h00);
        check("post-reset count", 32'(bus.count_o), 32'd0);

        // Randomized traffic against the queue model
        wp = '{90, 50, 20, 95};
        rp = '{20, 50, 90, 60};
        mq.delete();
        for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < 100; c++) begin
                model_cycle($urandom_range(0, 99) < wp[b], $urandom_range(0, 99) < rp[b],
                            8'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
